// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - BHT/BTB write-port and PC redirect controller
// Shares one table write port between the init sweep and branch resolution updates.
module bp_update_ctrl #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic              stall_in,
  input  logic              dec_valid,
  input  logic              dec_is_branch,
  input  logic              dec_taken,
  input  logic [ADDR_W-1:0] dec_target,
  input  logic [ADDR_W-1:0] dec_pc_plus2,
  input  logic [IDX_W-1:0]  dec_pc_idx,
  input  logic [1:0]        dec_pred,
  input  logic [ADDR_W-1:0] dec_pred_target,
  output logic              wen_BHT,
  output logic              wen_BTB,
  output logic [IDX_W-1:0]  widx,
  output logic [1:0]        bht_wdata,
  output logic [ADDR_W-1:0] btb_wdata,
  output logic              update_PC,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              flush_IF_ID,
  output logic              fetch_stall,
  output logic              init_busy,
  output logic [CNT_W-1:0]  cnt_branch,
  output logic [CNT_W-1:0]  cnt_redirect
);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_SQUASH} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [IDX_W-1:0]  sweep_idx;
  logic              resolve;
  logic              mis;
  logic              tmiss;
  logic              redirect;
  logic [1:0]        newc;

  assign resolve  = dec_valid & dec_is_branch & ~stall_in;
  assign mis      = dec_pred[1] != dec_taken;
  assign tmiss    = dec_pred_target != dec_target;
  assign redirect = (dec_taken & (mis | tmiss)) | (~dec_taken & dec_pred[1]);

  // 2-bit saturating counter step toward the actual outcome
  always_comb begin
    newc = dec_pred;
    if (dec_taken && dec_pred != 2'b11)
      newc = dec_pred + 2'b01;
    else if (!dec_taken && dec_pred != 2'b00)
      newc = dec_pred - 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_INIT;
      sweep_idx       <= '0;
      wen_BHT         <= 1'b0;
      wen_BTB         <= 1'b0;
      widx            <= '0;
      bht_wdata       <= 2'b00;
      btb_wdata       <= '0;
      update_PC       <= 1'b0;
      redirect_target <= '0;
      flush_IF_ID     <= 1'b0;
      fetch_stall     <= 1'b1;
      init_busy       <= 1'b1;
      cnt_branch      <= '0;
      cnt_redirect    <= '0;
    end else begin
      wen_BHT     <= 1'b0;
      wen_BTB     <= 1'b0;
      update_PC   <= 1'b0;
      flush_IF_ID <= 1'b0;
      case (state)
        S_INIT: begin
          wen_BHT     <= 1'b1;
          wen_BTB     <= 1'b1;
          widx        <= sweep_idx;
          bht_wdata   <= 2'b00;
          btb_wdata   <= '0;
          fetch_stall <= 1'b1;
          init_busy   <= 1'b1;
          sweep_idx   <= sweep_idx + IDX_ONE;
          if (sweep_idx == {IDX_W{1'b1}})
            state <= S_RUN;
        end
        default: begin
          fetch_stall <= 1'b0;
          init_busy   <= 1'b0;
          if (init_req) begin
            // re-init outranks any branch resolving this cycle
            state        <= S_INIT;
            sweep_idx    <= '0;
            cnt_branch   <= '0;
            cnt_redirect <= '0;
            fetch_stall  <= 1'b1;
            init_busy    <= 1'b1;
          end else if (state == S_SQUASH) begin
            state <= S_RUN;
          end else if (resolve) begin
            wen_BHT   <= newc != dec_pred;
            bht_wdata <= newc;
            wen_BTB   <= dec_taken & tmiss;
            btb_wdata <= dec_target;
            widx      <= dec_pc_idx;
            if (cnt_branch != {CNT_W{1'b1}})
              cnt_branch <= cnt_branch + CNT_ONE;
            if (redirect) begin
              update_PC       <= 1'b1;
              flush_IF_ID     <= 1'b1;
              redirect_target <= dec_taken ? dec_target : dec_pc_plus2;
              state           <= S_SQUASH;
              if (cnt_redirect != {CNT_W{1'b1}})
                cnt_redirect <= cnt_redirect + CNT_ONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Controller for the fetch-stage dynamic branch predictor's BHT/BTB write port and PC redirect path.
- Owns one shared table write port and uses it for two jobs: a post-reset/on-demand initialization sweep, and decode-stage branch resolution updates.
- Generates the registered redirect/flush controls for fetch and IF/ID, squashes the wrong-path slot after a redirect, and keeps saturating branch/redirect counters.

Parameters:
IDX_W, 4, BHT/BTB index width (2**IDX_W entries)
ADDR_W, 16, PC/target width
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
init_req  in  1  request table re-initialization (pulse)
stall_in  in  1  hazard stall; decode contents held, no resolution
dec_valid  in  1  decode slot holds a valid instruction
dec_is_branch  in  1  decode instruction is a branch
dec_taken  in  1  branch actually taken
dec_target  in  ADDR_W  actual branch target
dec_pc_plus2  in  ADDR_W  fall-through address of decode instruction
dec_pc_idx  in  IDX_W  table index of decode instruction (IF_ID_PC_curr)
dec_pred  in  2  IF/ID pipelined 2-bit prediction
dec_pred_target  in  ADDR_W  IF/ID pipelined predicted target
wen_BHT  out  1  BHT write enable
wen_BTB  out  1  BTB write enable
widx  out  IDX_W  table write index
bht_wdata  out  2  BHT write data
btb_wdata  out  ADDR_W  BTB write data
update_PC  out  1  fetch loads redirect_target
redirect_target  out  ADDR_W  PC to fetch on redirect
flush_IF_ID  out  1  kill IF/ID contents
fetch_stall  out  1  hold PC (high during INIT)
init_busy  out  1  sweep in progress
cnt_branch  out  CNT_W  resolved branches
cnt_redirect  out  CNT_W  redirects issued

Behaviour:
- The interface uses one clock, clk. Reset rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - State is INIT with sweep index 0.
  - init_busy=1 and fetch_stall=1.
  - wen_BHT, wen_BTB, update_PC and flush_IF_ID are 0.
  - widx, bht_wdata, btb_wdata and redirect_target are 0.
  - Both counters are 0.
- The FSM has three states: INIT, RUN and SQUASH.
- INIT:
  - Each cycle drives wen_BHT=wen_BTB=1, widx=sweep index, bht_wdata=2'b00, btb_wdata=0.
  - The sweep index increments from 0 to 2**IDX_W-1, so the sweep takes exactly 2**IDX_W write cycles.
  - fetch_stall=1 and init_busy=1 for the whole sweep.
  - Decode inputs and init_req are ignored.
  - After the last write, next state is RUN; fetch_stall and init_busy go to 0 and both wens go to 0.
- Resolution in RUN: a branch resolves at a posedge when dec_valid & dec_is_branch & !stall_in. Define:
  - mis = dec_pred[1] != dec_taken
  - tmiss = dec_pred_target != dec_target
  - newc = dec_pred saturating +1 if taken, -1 if not taken
- Outputs of a resolution, valid the next cycle for exactly one cycle:
  - wen_BHT = (newc != dec_pred), with bht_wdata = newc.
  - wen_BTB = dec_taken & tmiss, with btb_wdata = dec_target.
  - widx = dec_pc_idx.
  - redirect = (dec_taken & (mis | tmiss)) | (!dec_taken & dec_pred[1]).
  - On redirect: update_PC = 1, flush_IF_ID = 1, and redirect_target = dec_taken ? dec_target : dec_pc_plus2.
- Counters: cnt_branch increments on every resolution; cnt_redirect increments on every redirect. Both saturate at all-ones.
- State transitions:
  - RUN goes to SQUASH on a redirect.
  - SQUASH lasts one cycle. Decode inputs are ignored (wrong-path slot): no writes, no redirect, no counting. It then returns to RUN.
- Non-branch or invalid decode: all pulse outputs 0.
- stall_in=1 in RUN: no resolution, pulse outputs 0. The same branch resolves once, when stall_in drops.
- init_req in RUN or SQUASH:
  - Next state is INIT with the sweep index at 0, and both counters clear.
  - Init wins over a simultaneous resolution; that branch is dropped and not counted.
- rst_n asserted mid-sweep or mid-SQUASH returns immediately to the reset values, and the sweep restarts from 0.

Test Plan:
- Reset release → 16 cycles of wen_BHT=wen_BTB=1 with widx 0..15 and data 0, fetch_stall=1; then fetch_stall=0 and init_busy=0.
- Branch idx 3, pred=00, taken, target 0x0040, pred_target 0x0000 → next cycle: wen_BHT=1 with bht_wdata=01; wen_BTB=1 with btb_wdata=0x0040; update_PC=1 with redirect_target=0x0040; flush=1; cnt_branch=1; cnt_redirect=1.
- Branch pred=10, taken, target == pred_target 0x0100 → wen_BHT=1 with bht_wdata=11, wen_BTB=0, update_PC=0, cnt_redirect unchanged.
- Branch pred=11, not taken, pc_plus2 0x0022 → bht_wdata=10, update_PC=1 with redirect_target=0x0022; a mispredicting branch presented the following cycle (SQUASH) → no outputs, no count.
- Branch held with stall_in=1 for 3 cycles → no outputs during the stall; exactly one resolution when stall_in drops; cnt_branch +1.
- CNT_W=2, 5 redirecting branches → cnt_redirect saturates at 3; init_req together with a resolving branch → branch dropped, counters 0, 16-cycle sweep restarts at idx 0.
